// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider with per-channel divisor, high time and phase.
// Configuration goes through a shadow register that is applied at period wrap, sync, or while disabled.
module multi_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 62500000,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_divisor,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic              sync,
  input  logic [NUM_CH-1:0] enable,
  output logic [NUM_CH-1:0] divClk,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_DIV / 2);
  localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);

  logic [NUM_CH-1:0] pending;

  // Out-of-range channel selects never match, so they are always ready and go nowhere.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] div_q, high_q, phase_q, cnt_q;
    logic [CNT_W-1:0] div_sh, high_sh, phase_sh;
    logic [CNT_W-1:0] div_san, div_n, high_n, phase_n, cnt_n;
    logic             pend_q, en_q, div_clk_q, tick_q;
    logic             accept, wrap, apply;

    always_comb begin
      accept  = cfg_valid && !pend_q && (cfg_ch == CH_W'(g));
      wrap    = enable[g] && (cnt_q >= div_q - 1'b1);
      apply   = pend_q && (wrap || sync || !enable[g]);
      div_san = (div_sh < DIV_MIN) ? DIV_MIN : div_sh;
      div_n   = apply ? div_san : div_q;
      high_n  = apply ? high_sh : high_q;
      phase_n = phase_q;
      if (apply) phase_n = (phase_sh >= div_san) ? '0 : phase_sh;
      // Sync outranks both the wrap and the enable-rising restart.
      if (!enable[g])          cnt_n = '0;
      else if (sync)           cnt_n = phase_n;
      else if (!en_q || wrap)  cnt_n = '0;
      else                     cnt_n = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        div_q     <= DIV_RST;
        high_q    <= HIGH_RST;
        phase_q   <= '0;
        div_sh    <= '0;
        high_sh   <= '0;
        phase_sh  <= '0;
        cnt_q     <= '0;
        pend_q    <= 1'b0;
        en_q      <= 1'b0;
        div_clk_q <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        div_q     <= div_n;
        high_q    <= high_n;
        phase_q   <= phase_n;
        cnt_q     <= cnt_n;
        en_q      <= enable[g];
        div_clk_q <= enable[g] && (cnt_n < high_n);
        tick_q    <= enable[g] && (cnt_n == '0);
        if (accept) begin
          div_sh   <= cfg_divisor;
          high_sh  <= cfg_high;
          phase_sh <= cfg_phase;
        end
        if (apply)       pend_q <= 1'b0;
        else if (accept) pend_q <= 1'b1;
      end
    end

    assign pending[g] = pend_q;
    assign divClk[g]  = div_clk_q;
    assign tick[g]    = tick_q;
  end

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Multi-channel programmable clock divider for the beamformer timing path. It generates NUM_CH independent divided clocks from the 125 MHz board clock, plus one-cycle period ticks. Each channel has its own run-time divisor, high time (duty) and phase offset, updated glitch-free through a shadow-register handshake. A common sync input realigns all channels, which lets per-element transmit timing be phased against each other.

## Interface
- NUM_CH, 4: number of independent channels (≥1).
- CNT_W, 32: counter and configuration field width.
- DEFAULT_DIV, 62500000: divisor loaded at reset (2 Hz at 125 MHz); default high time DEFAULT_DIV/2, default phase 0.
- CH_W, max(1, clog2(NUM_CH)): channel select width (derived).

Ports:
- clock  in  1  reference clock, 125 MHz.
- reset  in  1  asynchronous, active-high.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready.
- cfg_ch  in  CH_W  target channel; values ≥ NUM_CH are accepted and ignored.
- cfg_divisor  in  CNT_W  period in clock cycles.
- cfg_high  in  CNT_W  cycles high per period.
- cfg_phase  in  CNT_W  counter start value applied on sync.
- sync  in  1  one-cycle strobe that realigns all channels.
- enable  in  NUM_CH  per-channel run enable.
- divClk  out  NUM_CH  divided clocks, registered.
- tick  out  NUM_CH  one-cycle pulse at each period start, registered.

## Operation
- Per channel:
  - Active registers: D (divisor), H (high time), P (phase).
  - Shadow registers and a pending flag.
  - Counter cnt, range 0..D-1.
- **Sanitisation**, applied when the shadow moves to active:
  - D<2 becomes 2.
  - P≥D becomes 0.
  - H is stored as given.
- **Output decode**, from the counter value after the edge:
  - divClk[i] = enable[i] && (cnt<H). H=0 gives constant low; H≥D gives constant high.
  - tick[i] = enable[i] && cnt==0.
- **Counting**: with enable[i] high, cnt increments each cycle. When cnt==D-1 it wraps to 0; this is the period boundary.
- **Disable**: with enable[i] low, cnt is held at 0 and divClk[i], tick[i] are 0.
- **Configuration handshake**:
  - cfg_ready = !pending[cfg_ch], combinational. It is 1 for an out-of-range cfg_ch.
  - An accepted write loads the shadow and sets pending.
- **Shadow apply**: the shadow is copied to active, and pending cleared, at the first of:
  - (a) a period-boundary wrap of that channel;
  - (b) a sync;
  - (c) any cycle in which enable[i] is low.
- **Sync**: all channels apply pending shadows. Each enabled channel then loads cnt with its (new) P. Disabled channels keep cnt=0.
- **Enable rising**: the counter starts at 0, so the first cycle after the edge shows tick=1.

## Timing
- Reset values:
  - cnt=0, divClk=0, tick=0, pending=0, cfg_ready=1.
  - D=DEFAULT_DIV, H=DEFAULT_DIV/2, P=0.
  - Shadows are discarded.
- Reset asserted mid-operation clears all outputs immediately, asynchronously.
- All outputs are registered and reflect the counter value loaded at the same edge. There is no combinational path from inputs to divClk/tick. cfg_ready is the only combinational output.
- Write latency:
  - A write accepted at edge k is in the shadow after k. pending is visible on cfg_ready in the cycle after k.
  - New D/H take effect from the cnt=0 cycle following the channel's next wrap. The period in progress always completes with the old values.
- Simultaneous events:
  - Write accepted at the same edge as a wrap or sync: the new values are not applied at that edge. They wait for the next boundary, sync, or disabled cycle.
  - sync and wrap on the same edge: sync wins, cnt=P.
  - sync while pending: the shadow is applied first, then the new P is loaded.
- Steady-state period is exactly D cycles, with H high cycles then D-H low cycles. Phase P means the channel runs P cycles ahead of a P=0 channel synced at the same edge.

## Test plan
- **Default run**: NUM_CH=2, CNT_W=8, DEFAULT_DIV=10. Release reset, enable=2'b11 → both divClk high 5 / low 5, tick every 10 cycles, first tick in the cycle after enable.
- **Handshake**: write ch1 D=4 H=1 mid-period → cfg_ready low for ch1 until ch1 wraps. The old 10-cycle period completes, then ch1 repeats high 1 / low 3. A second write while pending is not accepted.
- **Phase**: ch0 D=8 H=4 P=0, ch1 D=8 H=4 P=2, pulse sync → ch1 tick lands 6 cycles after ch0 tick (2 ahead), stable over 4 periods.
- **Edge values**: D=0 → period 2. H=0 → divClk constant 0 with ticks every D. H=9, D=8 → divClk constant 1. P=12, D=8 → sync loads 0.
- **Collisions**: write on the same edge as a wrap → applied one period later. Sync on the same edge as a wrap → cnt=P. cfg_ch=3 with NUM_CH=2 → accepted, no channel change.
- **Enable and reset**: deassert enable[0] mid-high → divClk[0]=0 the next cycle and the pending shadow applied. Reassert → tick the next cycle. Async reset mid-run → outputs 0 without a clock edge, defaults restored.
